kbd_event_ctrl: RTL

- Sequences the raw PS/2 scancode byte stream into key events and owns the "currently held key" state.
- Its `key_code`/`key_active` outputs drive the scancode-to-ASCII lookup and the seven-segment light enable.
- Decodes the `F0` break and `E0` extended prefixes, tracks shift state and counts key presses.
- Queues make/break events in a small ready/valid FIFO for a downstream consumer.

---
 rtl/kbd_event_ctrl.sv | 196 +++++++++++++++++++
 1 files changed

// File: rtl/kbd_event_ctrl.sv
// kbd_event_ctrl
// Turns the raw PS/2 scancode byte stream into make/break key events.
// It owns the "currently held key" state, the shift state and a press
// counter, and it queues every decoded event in a small ready/valid FIFO.
// Every output comes straight from a register.
module kbd_event_ctrl #(
  parameter int unsigned DEPTH   = 4,
  parameter logic [15:0] TIMEOUT = 16'd50000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] scan_data,
  input  logic       scan_valid,
  output logic [7:0] key_code,
  output logic       key_active,
  output logic       shift,
  output logic [7:0] press_count,
  output logic [9:0] ev_data,
  output logic       ev_valid,
  input  logic       ev_ready,
  output logic       overflow
);

  localparam int          AW        = $clog2(DEPTH);
  localparam logic [7:0]  SC_EXT    = 8'hE0;
  localparam logic [7:0]  SC_BRK    = 8'hF0;
  localparam logic [7:0]  SC_LSHIFT = 8'h12;
  localparam logic [7:0]  SC_RSHIFT = 8'h59;
  localparam logic [15:0] TMO_LAST  = TIMEOUT - 16'd1;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_BRK     = 2'd1,
    S_EXT     = 2'd2,
    S_EXT_BRK = 2'd3
  } state_t;

  // True for either shift key's scancode.
  function automatic logic is_shift_code(input logic [7:0] code);
    is_shift_code = (code == SC_LSHIFT) || (code == SC_RSHIFT);
  endfunction

  state_t      state, state_nxt;
  logic [15:0] tmo_cnt;

  // Decoded event for this cycle and the next held-key / shift / count values.
  logic        ev_push_p0;
  logic [9:0]  ev_wdata_p0;
  logic [7:0]  key_code_nxt;
  logic        key_active_nxt;
  logic        shift_nxt;
  logic        press_inc;

  // FIFO storage and pointers; the extra pointer bit tells full from empty.
  logic [9:0]  mem [DEPTH];
  logic [AW:0] wr_ptr, rd_ptr, wr_ptr_nxt, rd_ptr_nxt;
  logic        fifo_full, fifo_pop, push_acc, head_from_wr, empty_nxt;

  // ---- Stage p0: byte decode (FSM state register) ----
  // Prefix decoder state; only advanced by scan bytes or the timeout.
  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  // Next state: follow the prefix bytes, abandon a prefix after a long silence.
  always_comb begin
    state_nxt = state;
    if (scan_valid) begin
      case (state)
        S_IDLE: begin
          if (scan_data == SC_EXT)      state_nxt = S_EXT;
          else if (scan_data == SC_BRK) state_nxt = S_BRK;
          else                          state_nxt = S_IDLE;
        end
        S_EXT: begin
          if (scan_data == SC_BRK) state_nxt = S_EXT_BRK;
          else                     state_nxt = S_IDLE;
        end
        default: state_nxt = S_IDLE;
      endcase
    end else if ((state != S_IDLE) && (tmo_cnt == TMO_LAST)) begin
      state_nxt = S_IDLE;
    end
  end

  // Outputs of the decoder: event to queue and the held-key bookkeeping.
  always_comb begin
    ev_push_p0     = 1'b0;
    ev_wdata_p0    = 10'h000;
    key_code_nxt   = key_code;
    key_active_nxt = key_active;
    shift_nxt      = shift;
    press_inc      = 1'b0;
    if (scan_valid) begin
      case (state)
        S_IDLE: begin
          if ((scan_data != SC_EXT) && (scan_data != SC_BRK)) begin
            ev_push_p0  = 1'b1;
            ev_wdata_p0 = {1'b0, 1'b1, scan_data};
            if (is_shift_code(scan_data)) begin
              shift_nxt = 1'b1;
            end else if (!(key_active && (scan_data == key_code))) begin
              // A repeat of the held key is typematic and changes nothing here.
              key_code_nxt   = scan_data;
              key_active_nxt = 1'b1;
              press_inc      = 1'b1;
            end
          end
        end
        S_BRK: begin
          ev_push_p0  = 1'b1;
          ev_wdata_p0 = {1'b0, 1'b0, scan_data};
          if (is_shift_code(scan_data)) begin
            shift_nxt = 1'b0;
          end else if (key_active && (scan_data == key_code)) begin
            key_code_nxt   = 8'h00;
            key_active_nxt = 1'b0;
          end
        end
        S_EXT: begin
          if (scan_data != SC_BRK) begin
            ev_push_p0  = 1'b1;
            ev_wdata_p0 = {1'b1, 1'b1, scan_data};
          end
        end
        default: begin
          ev_push_p0  = 1'b1;
          ev_wdata_p0 = {1'b1, 1'b0, scan_data};
        end
      endcase
    end
  end

  // Prefix timeout: counts silent cycles in a prefix state, zero in IDLE.
  always_ff @(posedge clk) begin
    if (reset)                                 tmo_cnt <= 16'd0;
    else if (scan_valid || state_nxt == S_IDLE) tmo_cnt <= 16'd0;
    else                                       tmo_cnt <= tmo_cnt + 16'd1;
  end

  // ---- Stage p1: registered key state ----
  // Held key, shift and press counter all update on the edge ending the byte.
  always_ff @(posedge clk) begin
    if (reset) begin
      key_code    <= 8'h00;
      key_active  <= 1'b0;
      shift       <= 1'b0;
      press_count <= 8'h00;
    end else begin
      key_code    <= key_code_nxt;
      key_active  <= key_active_nxt;
      shift       <= shift_nxt;
      press_count <= press_count + {7'd0, press_inc};
    end
  end

  // ---- Stage p1: event FIFO ----
  // Accept/pop decisions and next pointer values.
  always_comb begin
    fifo_full    = (wr_ptr[AW] != rd_ptr[AW]) &&
                   (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    fifo_pop     = ev_valid && ev_ready;
    push_acc     = ev_push_p0 && (!fifo_full || fifo_pop);
    wr_ptr_nxt   = wr_ptr + {{AW{1'b0}}, push_acc};
    rd_ptr_nxt   = rd_ptr + {{AW{1'b0}}, fifo_pop};
    empty_nxt    = (wr_ptr_nxt == rd_ptr_nxt);
    // The new head is the entry being written only when the FIFO drains to empty first.
    head_from_wr = push_acc && (wr_ptr == rd_ptr_nxt);
  end

  // Storage array; contents are meaningless until pointed at, so no reset.
  always_ff @(posedge clk) begin
    if (push_acc) mem[wr_ptr[AW-1:0]] <= ev_wdata_p0;
  end

  // Pointers, registered head entry/valid and the sticky overflow flag.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      ev_valid <= 1'b0;
      ev_data  <= 10'h000;
      overflow <= 1'b0;
    end else begin
      wr_ptr   <= wr_ptr_nxt;
      rd_ptr   <= rd_ptr_nxt;
      ev_valid <= !empty_nxt;
      if (empty_nxt)         ev_data <= 10'h000;
      else if (head_from_wr) ev_data <= ev_wdata_p0;
      else                   ev_data <= mem[rd_ptr_nxt[AW-1:0]];
      if (ev_push_p0 && fifo_full && !fifo_pop) overflow <= 1'b1;
    end
  end

endmodule
